calendar_unit: RTL and testbench

CALENDAR_UNIT -- requirements
Module: calendar_unit

---
 rtl/calendar_unit_if.sv | 31 +++
 rtl/calendar_unit.sv | 169 ++++++++++++++++
 tb/tb_calendar_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/calendar_unit_if.sv
// Calendar unit signal bundle: tick/set-mode controls in, date fields out.
interface calendar_unit_if #(
  parameter int YEAR_BITS = 7
);
  logic                 DayTick;
  logic                 Timeset;
  logic                 DateAdv;
  logic                 MonthAdv;
  logic                 YearAdv;
  logic                 DayAdv;
  logic [4:0]           Date;
  logic [3:0]           Month;
  logic [YEAR_BITS-1:0] Year;
  logic [2:0]           Dow;
  logic                 Leap;
  logic [3:0]           Date1;
  logic [3:0]           Date0;
  logic [3:0]           Month1;
  logic [3:0]           Month0;
  logic                 NewYear;

  modport slave (
    input  DayTick, Timeset, DateAdv, MonthAdv, YearAdv, DayAdv,
    output Date, Month, Year, Dow, Leap, Date1, Date0, Month1, Month0, NewYear
  );

  modport master (
    output DayTick, Timeset, DateAdv, MonthAdv, YearAdv, DayAdv,
    input  Date, Month, Year, Dow, Leap, Date1, Date0, Month1, Month0, NewYear
  );
endinterface

// File: rtl/calendar_unit.sv
// Calendar unit: date/month/year/day-of-week tracking with a set mode.
// Leap year derived from mod-4/100/400 counters that step with Year.
module calendar_unit #(
  parameter int BASE_YEAR = 2000,
  parameter int YEAR_BITS = 7,
  parameter int START_DOW = 6,
  parameter int LEAP_EN   = 1
) (
  input logic            Clk,
  input logic            Reset,
  calendar_unit_if.slave cal
);

  localparam logic [1:0] M4_RST   = 2'(BASE_YEAR % 4);
  localparam logic [6:0] M100_RST = 7'(BASE_YEAR % 100);
  localparam logic [8:0] M400_RST = 9'(BASE_YEAR % 400);
  localparam logic [2:0] DOW_RST  = 3'(START_DOW);

  logic [4:0]           date_q, date_d;
  logic [3:0]           month_q, month_d;
  logic [YEAR_BITS-1:0] year_q, year_d;
  logic [2:0]           dow_q, dow_d;
  logic [1:0]           m4_q, m4_d;
  logic [6:0]           m100_q, m100_d;
  logic [8:0]           m400_q, m400_d;
  logic                 new_year_q, new_year_d;

  // Year+1 candidate, shared by the tick rollover and YearAdv
  logic [YEAR_BITS-1:0] year_inc;
  logic [1:0]           m4_inc;
  logic [6:0]           m100_inc;
  logic [8:0]           m400_inc;
  logic                 leap_cur, leap_inc;
  logic [2:0]           dow_inc;

  function automatic logic is_leap(input logic [1:0] m4, input logic [6:0] m100,
                                   input logic [8:0] m400);
    return (LEAP_EN != 0) && (m4 == 2'd0) && ((m100 != 7'd0) || (m400 == 9'd0));
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return lp ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Next-year counters; on wrap to offset 0 the counters restart at BASE_YEAR
  always_comb begin
    year_inc = YEAR_BITS'(year_q + 1'b1);
    if (year_inc == '0) begin
      m4_inc   = M4_RST;
      m100_inc = M100_RST;
      m400_inc = M400_RST;
    end else begin
      m4_inc   = m4_q + 2'd1;
      m100_inc = (m100_q == 7'd99)  ? 7'd0 : m100_q + 7'd1;
      m400_inc = (m400_q == 9'd399) ? 9'd0 : m400_q + 9'd1;
    end
    leap_cur = is_leap(m4_q, m100_q, m400_q);
    leap_inc = is_leap(m4_inc, m100_inc, m400_inc);
    dow_inc  = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
  end

  // Next state: set mode applies Year, then Month, then Date; else midnight carry
  always_comb begin
    logic       lp;
    logic [3:0] m;
    logic [4:0] len;
    date_d     = date_q;
    month_d    = month_q;
    year_d     = year_q;
    dow_d      = dow_q;
    m4_d       = m4_q;
    m100_d     = m100_q;
    m400_d     = m400_q;
    new_year_d = 1'b0;
    lp         = leap_cur;
    m          = month_q;
    len        = 5'd31;
    if (cal.Timeset) begin
      if (cal.YearAdv) begin
        year_d = year_inc;
        m4_d   = m4_inc;
        m100_d = m100_inc;
        m400_d = m400_inc;
        lp     = leap_inc;
      end
      if (cal.MonthAdv) m = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
      month_d = m;
      len     = month_len(m, lp);
      if (cal.DateAdv) date_d = (date_q >= len) ? 5'd1 : date_q + 5'd1;
      else             date_d = (date_q > len) ? len : date_q;
      if (cal.DayAdv) dow_d = dow_inc;
    end else if (cal.DayTick) begin
      dow_d = dow_inc;
      len   = month_len(month_q, leap_cur);
      if (date_q >= len) begin
        date_d = 5'd1;
        if (month_q == 4'd12) begin
          month_d    = 4'd1;
          year_d     = year_inc;
          m4_d       = m4_inc;
          m100_d     = m100_inc;
          m400_d     = m400_inc;
          new_year_d = 1'b1;
        end else begin
          month_d = month_q + 4'd1;
        end
      end else begin
        date_d = date_q + 5'd1;
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      date_q     <= 5'd1;
      month_q    <= 4'd1;
      year_q     <= '0;
      dow_q      <= DOW_RST;
      m4_q       <= M4_RST;
      m100_q     <= M100_RST;
      m400_q     <= M400_RST;
      new_year_q <= 1'b0;
    end else begin
      date_q     <= date_d;
      month_q    <= month_d;
      year_q     <= year_d;
      dow_q      <= dow_d;
      m4_q       <= m4_d;
      m100_q     <= m100_d;
      m400_q     <= m400_d;
      new_year_q <= new_year_d;
    end
  end

  // BCD split of the registered Date and Month, no extra latency
  always_comb begin
    cal.Date1  = 4'd0;
    cal.Date0  = date_q[3:0];
    cal.Month1 = 4'd0;
    cal.Month0 = month_q;
    if (date_q >= 5'd30) begin
      cal.Date1 = 4'd3;
      cal.Date0 = 4'(date_q - 5'd30);
    end else if (date_q >= 5'd20) begin
      cal.Date1 = 4'd2;
      cal.Date0 = 4'(date_q - 5'd20);
    end else if (date_q >= 5'd10) begin
      cal.Date1 = 4'd1;
      cal.Date0 = 4'(date_q - 5'd10);
    end
    if (month_q >= 4'd10) begin
      cal.Month1 = 4'd1;
      cal.Month0 = month_q - 4'd10;
    end
  end

  assign cal.Date    = date_q;
  assign cal.Month   = month_q;
  assign cal.Year    = year_q;
  assign cal.Dow     = dow_q;
  assign cal.Leap    = leap_cur;
  assign cal.NewYear = new_year_q;

endmodule

// File: tb/tb_calendar_unit.sv
// Directed bench for calendar_unit: set mode, rollovers, leap rules, reset.
module tb_calendar_unit;
  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  calendar_unit_if #(.YEAR_BITS(7)) cal ();

  calendar_unit #(
    .BASE_YEAR(2000), .YEAR_BITS(7), .START_DOW(6), .LEAP_EN(1)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .cal  (cal.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int d, input int m, input int y);
    chk({tag, ".date"},  32'(cal.Date),  32'(d));
    chk({tag, ".month"}, 32'(cal.Month), 32'(m));
    chk({tag, ".year"},  32'(cal.Year),  32'(y));
  endtask

  // Drive inputs at a falling edge, hold for n rising edges, then release
  task automatic run(input bit ts, input bit dt, input bit da, input bit ma,
                     input bit ya, input bit wa, input int n);
    cal.Timeset = ts; cal.DayTick = dt; cal.DateAdv = da;
    cal.MonthAdv = ma; cal.YearAdv = ya; cal.DayAdv = wa;
    repeat (n) @(negedge Clk);
    cal.Timeset = 0; cal.DayTick = 0; cal.DateAdv = 0;
    cal.MonthAdv = 0; cal.YearAdv = 0; cal.DayAdv = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    cal.Timeset = 0; cal.DayTick = 0; cal.DateAdv = 0;
    cal.MonthAdv = 0; cal.YearAdv = 0; cal.DayAdv = 0;
    repeat (2) @(negedge Clk);

    // Reset state
    chk_date("rst", 1, 1, 0);
    chk("rst.dow",  32'(cal.Dow), 6);
    chk("rst.leap", 32'(cal.Leap), 1);
    chk("rst.ny",   32'(cal.NewYear), 0);
    chk("rst.d1",   32'(cal.Date1), 0);
    chk("rst.d0",   32'(cal.Date0), 1);
    chk("rst.m0",   32'(cal.Month0), 1);
    Reset = 1'b0;

    // Set to 12/31 year 0
    run(1, 0, 0, 1, 0, 0, 11);
    run(1, 0, 1, 0, 0, 0, 30);
    chk_date("set1231", 31, 12, 0);
    chk("set1231.d1", 32'(cal.Date1), 3);
    chk("set1231.d0", 32'(cal.Date0), 1);
    chk("set1231.m1", 32'(cal.Month1), 1);
    chk("set1231.m0", 32'(cal.Month0), 2);
    chk("set1231.dow", 32'(cal.Dow), 6);

    // New-year rollover
    run(0, 1, 0, 0, 0, 0, 1);
    chk_date("ny", 1, 1, 1);
    chk("ny.leap", 32'(cal.Leap), 0);
    chk("ny.pulse", 32'(cal.NewYear), 1);
    chk("ny.dow", 32'(cal.Dow), 0);
    run(0, 0, 0, 0, 0, 0, 1);
    chk("ny.pulse_end", 32'(cal.NewYear), 0);
    chk_date("ny.hold", 1, 1, 1);

    // Leap-day handling: 2000 leap, 2001 not, 2100 not
    do_reset();
    run(1, 0, 0, 1, 0, 0, 1);
    run(1, 0, 1, 0, 0, 0, 27);
    chk_date("y0feb28", 28, 2, 0);
    run(0, 1, 0, 0, 0, 0, 1);
    chk_date("y0feb29", 29, 2, 0);
    run(0, 1, 0, 0, 0, 0, 1);
    chk_date("y0mar1", 1, 3, 0);
    chk("y0mar1.ny", 32'(cal.NewYear), 0);
    run(1, 0, 0, 0, 1, 0, 1);
    run(1, 0, 0, 1, 0, 0, 11);
    run(1, 0, 1, 0, 0, 0, 27);
    chk_date("y1feb28", 28, 2, 1);
    run(0, 1, 0, 0, 0, 0, 1);
    chk_date("y1mar1", 1, 3, 1);
    run(1, 0, 0, 0, 1, 0, 99);
    chk("y100.leap", 32'(cal.Leap), 0);
    run(1, 0, 0, 1, 0, 0, 11);
    run(1, 0, 1, 0, 0, 0, 27);
    chk_date("y100feb28", 28, 2, 100);
    run(0, 1, 0, 0, 0, 0, 1);
    chk_date("y100mar1", 1, 3, 100);

    // Set-mode clamping and combined advances
    do_reset();
    run(1, 0, 1, 0, 0, 0, 30);
    chk_date("jan31", 31, 1, 0);
    run(1, 0, 0, 1, 0, 0, 1);
    chk_date("clamp.feb29", 29, 2, 0);
    run(1, 0, 0, 0, 1, 0, 1);
    chk_date("clamp.feb28", 28, 2, 1);
    run(1, 0, 0, 1, 0, 0, 2);
    run(1, 0, 1, 0, 0, 0, 2);
    chk_date("apr30", 30, 4, 1);
    run(1, 0, 1, 1, 0, 0, 1);
    chk_date("may31", 31, 5, 1);
    chk("set.dow_held", 32'(cal.Dow), 6);
    chk("set.ny_quiet", 32'(cal.NewYear), 0);
    run(1, 0, 0, 0, 0, 1, 1);
    chk("dayadv.wrap", 32'(cal.Dow), 0);

    // DayTick in set mode is dropped, not queued
    run(1, 1, 0, 0, 0, 0, 1);
    chk_date("drop", 31, 5, 1);
    run(0, 0, 0, 0, 0, 0, 1);
    chk_date("drop.noqueue", 31, 5, 1);
    chk("drop.dow", 32'(cal.Dow), 0);

    // Year offset wrap 127 -> 0 restores leap counters
    run(1, 0, 0, 0, 1, 0, 126);
    run(1, 0, 0, 1, 0, 0, 7);
    chk_date("dec30", 30, 12, 127);
    run(1, 0, 1, 0, 0, 0, 1);
    chk_date("dec31", 31, 12, 127);
    chk("y127.leap", 32'(cal.Leap), 0);
    run(0, 1, 0, 0, 0, 0, 1);
    chk_date("wrap", 1, 1, 0);
    chk("wrap.leap", 32'(cal.Leap), 1);
    chk("wrap.ny", 32'(cal.NewYear), 1);
    chk("wrap.dow", 32'(cal.Dow), 1);

    // Asynchronous reset between clock edges during a DayTick
    run(1, 0, 1, 0, 0, 0, 4);
    chk_date("jan5", 5, 1, 0);
    cal.DayTick = 1'b1;
    #2 Reset = 1'b1;
    #1;
    chk_date("async", 1, 1, 0);
    chk("async.dow",  32'(cal.Dow), 6);
    chk("async.ny",   32'(cal.NewYear), 0);
    chk("async.leap", 32'(cal.Leap), 1);
    cal.DayTick = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk_date("async.hold", 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
